// File: rtl/forwarding_unit.sv
// EX-stage operand forwarding control for the 5-stage MIPS pipeline, with
// registered select copies and saturating forwarding-event counters.
module forwarding_unit #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EX_MEM_regWrite,
  input  logic              MEM_WB_regWrite,
  input  logic [REG_AW-1:0] ID_EX_rs,
  input  logic [REG_AW-1:0] ID_EX_rt,
  input  logic [REG_AW-1:0] EX_MEM_rd,
  input  logic [REG_AW-1:0] MEM_WB_rd,
  input  logic              stats_clr,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic [1:0]        ForwardA_q,
  output logic [1:0]        ForwardB_q,
  output logic [CNT_W-1:0]  fwd_ex_cnt,
  output logic [CNT_W-1:0]  fwd_mem_cnt
);

  typedef enum logic [1:0] {
    SEL_RF = 2'b00,
    SEL_WB = 2'b01,
    SEL_EX = 2'b10
  } fwd_sel_e;

  fwd_sel_e sel_a;
  fwd_sel_e sel_b;
  logic     ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b;
  logic     any_ex, any_wb;

  // Register $0 is hardwired to zero, so a write to it must never be forwarded.
  assign ex_hit_a = EX_MEM_regWrite && (EX_MEM_rd != '0) && (EX_MEM_rd == ID_EX_rs);
  assign ex_hit_b = EX_MEM_regWrite && (EX_MEM_rd != '0) && (EX_MEM_rd == ID_EX_rt);
  assign wb_hit_a = MEM_WB_regWrite && (MEM_WB_rd != '0) && (MEM_WB_rd == ID_EX_rs);
  assign wb_hit_b = MEM_WB_regWrite && (MEM_WB_rd != '0) && (MEM_WB_rd == ID_EX_rt);

  // EX/MEM holds the newer value, so it wins over MEM/WB.
  always_comb begin
    sel_a = SEL_RF;
    if (ex_hit_a)      sel_a = SEL_EX;
    else if (wb_hit_a) sel_a = SEL_WB;
  end

  always_comb begin
    sel_b = SEL_RF;
    if (ex_hit_b)      sel_b = SEL_EX;
    else if (wb_hit_b) sel_b = SEL_WB;
  end

  assign ForwardA = sel_a;
  assign ForwardB = sel_b;

  assign any_ex = (sel_a == SEL_EX) || (sel_b == SEL_EX);
  assign any_wb = (sel_a == SEL_WB) || (sel_b == SEL_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ForwardA_q <= '0;
      ForwardB_q <= '0;
    end else begin
      ForwardA_q <= sel_a;
      ForwardB_q <= sel_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_ex_cnt  <= '0;
      fwd_mem_cnt <= '0;
    end else if (stats_clr) begin
      fwd_ex_cnt  <= '0;
      fwd_mem_cnt <= '0;
    end else begin
      if (any_ex && (fwd_ex_cnt != '1))  fwd_ex_cnt  <= fwd_ex_cnt + CNT_W'(1);
      if (any_wb && (fwd_mem_cnt != '1)) fwd_mem_cnt <= fwd_mem_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_forwarding_unit.sv
// Self-checking bench for forwarding_unit: directed cases plus random traffic
// against an event-counting reference model; a narrow-counter copy covers saturation.
module tb_forwarding_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ex_rw, wb_rw, stats_clr;
  logic [4:0] rs, rt, ex_rd, wb_rd;

  logic [1:0]  fa, fb, fa_q, fb_q;
  logic [15:0] ex_cnt, wb_cnt;
  logic [1:0]  fa2, fb2, fa2_q, fb2_q;
  logic [1:0]  ex_cnt2, wb_cnt2;

  int unsigned n_vec  = 0;
  int unsigned n_errs = 0;

  // Reference state: registered selects and raw event counts since clear/reset.
  logic [1:0]  exp_aq, exp_bq;
  int unsigned ex_ev, wb_ev;

  always #5 clk = ~clk;

  forwarding_unit #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .EX_MEM_regWrite(ex_rw), .MEM_WB_regWrite(wb_rw),
    .ID_EX_rs(rs), .ID_EX_rt(rt), .EX_MEM_rd(ex_rd), .MEM_WB_rd(wb_rd),
    .stats_clr(stats_clr),
    .ForwardA(fa), .ForwardB(fb), .ForwardA_q(fa_q), .ForwardB_q(fb_q),
    .fwd_ex_cnt(ex_cnt), .fwd_mem_cnt(wb_cnt)
  );

  forwarding_unit #(.REG_AW(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .EX_MEM_regWrite(ex_rw), .MEM_WB_regWrite(wb_rw),
    .ID_EX_rs(rs), .ID_EX_rt(rt), .EX_MEM_rd(ex_rd), .MEM_WB_rd(wb_rd),
    .stats_clr(stats_clr),
    .ForwardA(fa2), .ForwardB(fb2), .ForwardA_q(fa2_q), .ForwardB_q(fb2_q),
    .fwd_ex_cnt(ex_cnt2), .fwd_mem_cnt(wb_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_sel(input logic [4:0] src);
    if (ex_rw && ex_rd != 5'd0 && ex_rd == src) return 2'b10;
    if (wb_rw && wb_rd != 5'd0 && wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic drive(input logic erw, input logic [4:0] erd, input logic wrw,
                       input logic [4:0] wrd, input logic [4:0] s, input logic [4:0] t,
                       input logic clr);
    ex_rw = erw; ex_rd = erd; wb_rw = wrw; wb_rd = wrd; rs = s; rt = t; stats_clr = clr;
  endtask

  task automatic check_regs();
    check("fwdA_q", fa_q, exp_aq);
    check("fwdB_q", fb_q, exp_bq);
    check("ex_cnt", ex_cnt, sat(ex_ev, 65535));
    check("mem_cnt", wb_cnt, sat(wb_ev, 65535));
    check("ex_cnt_sat", ex_cnt2, sat(ex_ev, 3));
    check("mem_cnt_sat", wb_cnt2, sat(wb_ev, 3));
  endtask

  // Checks the combinational selects, clocks once, then checks registered state.
  task automatic cycle();
    logic [1:0] ea, eb;
    #1;
    ea = ref_sel(rs);
    eb = ref_sel(rt);
    check("fwdA", fa, ea);
    check("fwdB", fb, eb);
    @(posedge clk);
    exp_aq = ea;
    exp_bq = eb;
    if (stats_clr) begin
      ex_ev = 0;
      wb_ev = 0;
    end else begin
      if (ea == 2'b10 || eb == 2'b10) ex_ev++;
      if (ea == 2'b01 || eb == 2'b01) wb_ev++;
    end
    #1;
    check_regs();
  endtask

  initial begin
    exp_aq = 2'b00; exp_bq = 2'b00; ex_ev = 0; wb_ev = 0;
    rst_n = 1'b0;
    drive(1'b1, 5'd10, 1'b0, 5'd0, 5'd10, 5'd10, 1'b0);
    #1;
    check("fwdA_in_reset", fa, 2'b10);
    check("fwdB_in_reset", fb, 2'b10);
    check_regs();
    #2 rst_n = 1'b1;

    drive(1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  5'd0,  1'b0); cycle();
    drive(1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  5'd0,  1'b0); cycle();
    drive(1'b1, 5'd10, 1'b0, 5'd0,  5'd10, 5'd10, 1'b0); cycle();
    drive(1'b0, 5'd0,  1'b1, 5'd20, 5'd20, 5'd20, 1'b0); cycle();
    drive(1'b1, 5'd15, 1'b1, 5'd15, 5'd15, 5'd15, 1'b0); cycle();
    drive(1'b1, 5'd1,  1'b1, 5'd2,  5'd2,  5'd1,  1'b0); cycle();
    drive(1'b1, 5'd3,  1'b0, 5'd0,  5'd4,  5'd3,  1'b0); cycle();
    drive(1'b0, 5'd0,  1'b1, 5'd7,  5'd8,  5'd7,  1'b0); cycle();
    drive(1'b0, 5'd0,  1'b1, 5'd0,  5'd0,  5'd0,  1'b0); cycle();

    // Clear, then three EX-forwarding cycles, then clear again.
    drive(1'b1, 5'd10, 1'b0, 5'd0, 5'd10, 5'd10, 1'b1); cycle();
    drive(1'b1, 5'd10, 1'b0, 5'd0, 5'd10, 5'd10, 1'b0);
    repeat (3) cycle();
    check("ex_cnt_after3", ex_cnt, 32'd3);
    check("mem_cnt_after3", wb_cnt, 32'd0);
    drive(1'b1, 5'd10, 1'b0, 5'd0, 5'd10, 5'd10, 1'b1); cycle();

    // Hold MEM/WB forwarding long enough to saturate the 2-bit counters.
    drive(1'b0, 5'd0, 1'b1, 5'd9, 5'd9, 5'd1, 1'b0);
    repeat (5) cycle();
    check("mem_cnt_sat_hold", wb_cnt2, 32'd3);

    // Asynchronous reset in the middle of the clock-high phase.
    #2;
    rst_n = 1'b0;
    exp_aq = 2'b00; exp_bq = 2'b00; ex_ev = 0; wb_ev = 0;
    #1;
    check_regs();
    @(negedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_errs);
    $finish;
  end

endmodule

// File: doc/forwarding_unit.md
Name: forwarding_unit

Overview:
- Combinational EX-stage data-forwarding control for the 5-stage pipelined MIPS CPU.
- Compares ID/EX source registers (rs, rt) against EX/MEM and MEM/WB destination registers. Drives the 2-bit ALU operand mux selects ForwardA and ForwardB.
- Also provides registered copies of the selects and saturating forwarding-event counters for debug and performance observation.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of each forwarding-event counter.

Ports:
- clk  input  1  system clock; all registered state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- EX_MEM_regWrite  input  1  instruction in EX/MEM writes the register file.
- MEM_WB_regWrite  input  1  instruction in MEM/WB writes the register file.
- ID_EX_rs  input  REG_AW  source register 1 of the instruction in EX.
- ID_EX_rt  input  REG_AW  source register 2 of the instruction in EX.
- EX_MEM_rd  input  REG_AW  destination register in EX/MEM.
- MEM_WB_rd  input  REG_AW  destination register in MEM/WB.
- stats_clr  input  1  synchronous clear of both counters.
- ForwardA  output  2  ALU operand A select, combinational.
- ForwardB  output  2  ALU operand B select, combinational.
- ForwardA_q  output  2  ForwardA registered one cycle.
- ForwardB_q  output  2  ForwardB registered one cycle.
- fwd_ex_cnt  output  CNT_W  cycles with at least one operand forwarded from EX/MEM.
- fwd_mem_cnt  output  CNT_W  cycles with at least one operand forwarded from MEM/WB.

Behaviour:
- Encoding: 2'b00 = register-file value; 2'b10 = EX/MEM ALU result; 2'b01 = MEM/WB write-back value; 2'b11 is never driven.
- ForwardA, evaluated in priority order:
  - 10 if EX_MEM_regWrite && EX_MEM_rd != 0 && EX_MEM_rd == ID_EX_rs;
  - else 01 if MEM_WB_regWrite && MEM_WB_rd != 0 && MEM_WB_rd == ID_EX_rs;
  - else 00.
- ForwardB: identical rule using ID_EX_rt.
- EX/MEM has priority over MEM/WB when both match, because it is the newer value.
- Register $0 is never forwarded, even with regWrite asserted.
- ForwardA and ForwardB are purely combinational: zero latency, no dependence on clk or rst_n, valid during reset.
- ForwardA_q/ForwardB_q take the combinational values on each rising clk edge, giving 1-cycle latency.
- fwd_ex_cnt increments by 1 on a rising edge when ForwardA==10 or ForwardB==10. One increment per cycle even if both operands match.
- fwd_mem_cnt increments the same way for 01.
- Both counters saturate at all-ones and never wrap.
- stats_clr zeroes both counters on the next edge and overrides any increment in that cycle. It does not affect ForwardA_q/ForwardB_q.
- Reset: rst_n low asynchronously forces ForwardA_q, ForwardB_q, fwd_ex_cnt and fwd_mem_cnt to 0. Counting resumes on the first edge after rst_n rises.
- Inputs are treated as settled; X on inputs is not required to be handled.

Test Plan:
- All inputs 0 -> ForwardA=00, ForwardB=00. Also EX_MEM_regWrite=1, EX_MEM_rd=0, rs=rt=0 -> 00/00 (no $0 forwarding).
- EX_MEM_regWrite=1, EX_MEM_rd=10, rs=rt=10, MEM_WB_regWrite=0 -> 10/10. With MEM_WB_regWrite=1, MEM_WB_rd=20, rs=rt=20, EX_MEM_regWrite=0 -> 01/01.
- Both regWrite=1, EX_MEM_rd=MEM_WB_rd=15, rs=rt=15 -> 10/10 (EX priority). Then rt=1, rs=2, EX_MEM_rd=1, MEM_WB_rd=2 -> ForwardA=01, ForwardB=10.
- EX_MEM_regWrite=1, rt=3, rs=4, EX_MEM_rd=3 -> A=00, B=10. EX_MEM_regWrite=0, MEM_WB_regWrite=1, rt=7, rs=8, MEM_WB_rd=7 -> A=00, B=01.
- Clocked run: ForwardA_q/ForwardB_q equal the previous cycle's combinational values. After 3 cycles of the 10/10 case, fwd_ex_cnt=3 and fwd_mem_cnt=0. stats_clr for 1 cycle -> both 0.
- Force CNT_W=2: hold a forwarding case for 5 cycles -> counter stays at 3. Assert rst_n=0 mid-clock -> counters and _q outputs go 0 immediately, before any edge.
